// File: rtl/hsv_calib_ctrl.sv
// Frame-synchronous H/S/V window averaging for filter calibration.
// Define HSV_CALIB_ROUND_EN for round-half-up averages instead of floor.
module hsv_calib_ctrl #(
  parameter int WIN_LOG2 = 4,
  parameter int H_W      = 14,
  parameter int CW       = 13
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  vga_vs,
  input  logic                  pix_valid,
  input  logic [CW-1:0]         row,
  input  logic [CW-1:0]         col,
  input  logic [CW-1:0]         win_row,
  input  logic [CW-1:0]         win_col,
  input  logic signed [H_W-1:0] H_in,
  input  logic [7:0]            S_in,
  input  logic [7:0]            V_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic signed [H_W-1:0] H_avg,
  output logic [7:0]            S_avg,
  output logic [7:0]            V_avg,
  output logic [7:0]            frame_cnt
);

  localparam int NL   = 2 * WIN_LOG2;
  localparam int N    = 2 ** NL;
  localparam int SIDE = 2 ** WIN_LOG2;
  localparam int SHW  = H_W + NL;
  localparam int SSW  = 8 + NL;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_VS = 2'd1;
  localparam logic [1:0] ACCUM   = 2'd2;
  localparam logic [1:0] DIVIDE  = 2'd3;

  logic [1:0]            state;
  logic                  vs_d;
  logic [CW-1:0]         wr_q;
  logic [CW-1:0]         wc_q;
  logic signed [SHW-1:0] sum_h;
  logic [SSW-1:0]        sum_s;
  logic [SSW-1:0]        sum_v;
  logic [NL:0]           cnt;

  logic vs_fall;
  logic row_ok;
  logic col_ok;
  logic in_win;
  logic last;

  assign vs_fall = vs_d & ~vga_vs;

  // Far edge compared one bit wider so windows near max coord don't wrap.
  assign row_ok = ({1'b0, row} >= {1'b0, wr_q}) &&
                  ({1'b0, row} < ({1'b0, wr_q} + (CW+1)'(SIDE)));
  assign col_ok = ({1'b0, col} >= {1'b0, wc_q}) &&
                  ({1'b0, col} < ({1'b0, wc_q} + (CW+1)'(SIDE)));
  assign in_win = pix_valid && row_ok && col_ok;
  assign last   = in_win && (cnt == (NL+1)'(N - 1));

  assign busy = (state != IDLE);

  logic signed [SHW:0] h_ext;
  logic [SSW:0]        s_ext;
  logic [SSW:0]        v_ext;
  logic [SSW:0]        s_sh;
  logic [SSW:0]        v_sh;
  logic [H_W-1:0]      h_div;
  logic [7:0]          s_div;
  logic [7:0]          v_div;

  always_comb begin
    h_ext = {sum_h[SHW-1], sum_h};
    s_ext = {1'b0, sum_s};
    v_ext = {1'b0, sum_v};
`ifdef HSV_CALIB_ROUND_EN
    h_ext = h_ext + (SHW+1)'(N / 2);
    s_ext = s_ext + (SSW+1)'(N / 2);
    v_ext = v_ext + (SSW+1)'(N / 2);
`endif
    h_div = H_W'(h_ext >>> NL);
    s_sh  = s_ext >> NL;
    v_sh  = v_ext >> NL;
    s_div = (|s_sh[SSW:8]) ? 8'hff : s_sh[7:0];
    v_div = (|v_sh[SSW:8]) ? 8'hff : v_sh[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      vs_d      <= 1'b0;
      wr_q      <= '0;
      wc_q      <= '0;
      sum_h     <= '0;
      sum_s     <= '0;
      sum_v     <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      H_avg     <= '0;
      S_avg     <= '0;
      V_avg     <= '0;
      frame_cnt <= '0;
    end else begin
      vs_d <= vga_vs;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            wr_q  <= win_row;
            wc_q  <= win_col;
            err   <= 1'b0;
            sum_h <= '0;
            sum_s <= '0;
            sum_v <= '0;
            cnt   <= '0;
            state <= WAIT_VS;
          end
        end
        WAIT_VS: begin
          if (vs_fall) state <= ACCUM;
        end
        ACCUM: begin
          if (in_win) begin
            sum_h <= sum_h + {{NL{H_in[H_W-1]}}, H_in};
            sum_s <= sum_s + SSW'(S_in);
            sum_v <= sum_v + SSW'(V_in);
            cnt   <= cnt + (NL+1)'(1);
          end
          // The Nth sample wins over a coincident frame boundary.
          if (last) begin
            state <= DIVIDE;
          end else if (vs_fall) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        DIVIDE: begin
          H_avg     <= h_div;
          S_avg     <= s_div;
          V_avg     <= v_div;
          done      <= 1'b1;
          frame_cnt <= frame_cnt + 8'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
